// File: rtl/switch_debounce_ctrl.sv
// Multi-channel switch conditioner: 2-flop synchronizers, a shared sample-tick
// prescaler and one debounce FSM per channel producing a clean level plus
// single-cycle rise/fall pulses.

// Per-channel debounce FSM. It only advances on tick and sees the synchronized input.
module sw_debounce_lane #(
  parameter int STABLE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, rise_d, fall_d;

  // Register the state, counter and outputs together so outputs move on the transition edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LO;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // Next-state logic. Pulses default low so they last exactly one clock, even when no tick arrives.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        LO: begin
          if (din) begin
            state_d = WAIT_HI;
            cnt_d   = CW'(1);
          end
        end
        WAIT_HI: begin
          if (!din) begin
            state_d = LO;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == CW'(STABLE)) begin
            state_d = HI;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        HI: begin
          if (!din) begin
            state_d = WAIT_LO;
            cnt_d   = CW'(1);
          end
        end
        WAIT_LO: begin
          if (din) begin
            state_d = HI;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == CW'(STABLE)) begin
            state_d = LO;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = LO;
          cnt_d   = '0;
        end
      endcase
    end
  end
endmodule

// Top: synchronizers and prescaler are shared infrastructure; channels are independent lanes.
module switch_debounce_ctrl #(
  parameter int N_SW   = 4,
  parameter int DIV    = 16,
  parameter int STABLE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            tick
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [N_SW-1:0] s1, s2;
  logic [PW-1:0]   pcnt;

  // Two-flop synchronizer. It runs regardless of enable so s2 is always current.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Sample prescaler. Counts 0..DIV-1 while enabled and holds when frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pcnt <= '0;
    else if (enable)
      pcnt <= (pcnt == PW'(DIV - 1)) ? '0 : pcnt + PW'(1);
  end

  assign tick = enable && (pcnt == PW'(DIV - 1));

  for (genvar g = 0; g < N_SW; g++) begin : g_lane
    sw_debounce_lane #(.STABLE(STABLE)) u_lane (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .din   (s2[g]),
      .level (sw_level[g]),
      .rise  (sw_rise[g]),
      .fall  (sw_fall[g])
    );
  end
endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl with DIV=4 and STABLE=3. Expected values are hand-derived.
module tb_switch_debounce_ctrl;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_level, sw_rise, sw_fall;
  logic         tick;

  int n_chk  = 0;
  int n_pass = 0;

  switch_debounce_ctrl #(.N_SW(N), .DIV(4), .STABLE(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .sw_raw   (sw_raw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .tick     (tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock edge, then settle to the falling edge for sampling and driving.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Hold reset for a few clocks, then release on a falling edge with the given raw value.
  task automatic do_reset(input logic [N-1:0] raw);
    reset  = 1'b1;
    sw_raw = '0;
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    sw_raw = raw;
  endtask

  initial begin
    int nf, nlow, nr, first;
    reset  = 1'b1;
    enable = 1'b1;
    sw_raw = '0;
    repeat (2) @(negedge clock);
    chk("rst_level", 32'(sw_level), 0);
    chk("rst_rise",  32'(sw_rise),  0);
    chk("rst_fall",  32'(sw_fall),  0);
    chk("rst_tick",  32'(tick),     0);

    // T1: sw_raw[0] high from release; ticks after edges 3,7,11; level rises at edge 12.
    do_reset(4'b0001);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("t1_tick_e%0d", k),  32'(tick),     32'(k % 4 == 3));
      chk($sformatf("t1_level_e%0d", k), 32'(sw_level), (k >= 12) ? 32'h1 : 32'h0);
      chk($sformatf("t1_rise_e%0d", k),  32'(sw_rise),  (k == 12) ? 32'h1 : 32'h0);
    end

    // T2: 2-clock low glitch in HI yields at most one low sample and must not drop the level.
    nf = 0; nlow = 0;
    sw_raw[0] = 1'b0;
    for (int k = 0; k < 22; k++) begin
      if (k == 2) sw_raw[0] = 1'b1;
      step();
      if (sw_fall[0])   nf++;
      if (!sw_level[0]) nlow++;
    end
    chk("t2_no_fall", 32'(nf), 0);
    chk("t2_level_held", 32'(nlow), 0);

    // T3: channel 1 bounces every 3 clocks for 40 clocks, then holds high.
    nr = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw_raw[1] = ~sw_raw[1];
      step();
      if (sw_rise[1]) nr++;
    end
    chk("t3_bounce_no_rise", 32'(nr), 0);
    sw_raw[1] = 1'b1;
    nr = 0; first = 99;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (sw_rise[1]) begin
        nr++;
        if (first == 99) first = j;
      end
    end
    chk("t3_one_rise", 32'(nr), 1);
    chk("t3_latency_ok", 32'(first <= 14), 1);
    chk("t3_level", 32'(sw_level), 32'h3);

    // T4: all channels rise together; level and rise assert on edge 12 for every bit.
    do_reset(4'b1111);
    first = 99; nf = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (sw_fall != 0) nf++;
      if (sw_rise != 0 && first == 99) begin
        first = k;
        chk("t4_rise_all", 32'(sw_rise), 32'hF);
        chk("t4_level_all", 32'(sw_level), 32'hF);
      end
    end
    chk("t4_rise_edge", 32'(first), 12);
    chk("t4_rise_cleared", 32'(sw_rise), 0);
    chk("t4_no_fall", 32'(nf), 0);

    // T5: freeze after two high samples, then confirm the third sample lands on the first tick after re-enable.
    do_reset(4'b0001);
    repeat (8) step();
    enable = 1'b0;
    nf = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tick || sw_level != 0 || sw_rise != 0 || sw_fall != 0) nf++;
    end
    chk("t5_frozen", 32'(nf), 0);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t5_tick_e%0d", k),  32'(tick),     32'(k == 3));
      chk($sformatf("t5_level_e%0d", k), 32'(sw_level), (k >= 4) ? 32'h1 : 32'h0);
    end

    // T6: asynchronous reset in WAIT_LO clears the level immediately with no fall pulse.
    sw_raw[0] = 1'b0;
    repeat (4) step();
    chk("t6_level_before", 32'(sw_level), 1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("t6_async_level", 32'(sw_level), 0);
    chk("t6_async_fall",  32'(sw_fall),  0);
    chk("t6_async_tick",  32'(tick),     0);
    step();
    chk("t6_rst_fall", 32'(sw_fall), 0);
    reset  = 1'b0;
    sw_raw = 4'b0001;
    nr = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (sw_rise[0]) nr++;
    end
    chk("t6_resume_rise", 32'(nr), 1);
    chk("t6_resume_level", 32'(sw_level), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
